// File: rtl/pong_pkg.sv
// Shared Pong types and 640x480 timing constants.
// Kept in one place so the scheduler and display timing agree.
package pong_pkg;

  localparam int H_ACTIVE_END = 639;
  localparam int V_ACTIVE_END = 479;
  localparam int LINE_LAST    = 799;
  localparam int SCREEN_LAST  = 524;

  typedef enum logic [1:0] {
    ATTRACT = 2'd0,
    SERVE   = 2'd1,
    PLAY    = 2'd2,
    OVER    = 2'd3
  } game_state_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PAD   = 2'd1,
    S_BALL  = 2'd2,
    S_SCORE = 2'd3
  } seq_state_t;

  // mask bit 0 = pad, 1 = ball, 2 = score; lowest set bit runs first
  function automatic seq_state_t pick_phase(
    input logic [2:0] m
  );
    if (m[0])      return S_PAD;
    else if (m[1]) return S_BALL;
    else if (m[2]) return S_SCORE;
    else           return S_IDLE;
  endfunction

endpackage

// File: rtl/pong_frame_seq.sv
// Per-frame update scheduler and game-mode FSM for Pong.
// Define PONG_PAUSE_EN to add the pause_btn input and paused output.
module pong_frame_seq
  import pong_pkg::*;
#(
  parameter int VA_END       = V_ACTIVE_END,
  parameter int SCREEN       = SCREEN_LAST,
  parameter int SERVE_FRAMES = 60,
  parameter int SCW          = 8
) (
  input  logic        clk_pix,
  input  logic        rst_pix,
  input  logic [9:0]  sx,
  input  logic [9:0]  sy,
  input  logic        start_btn,
  input  logic        point_scored,
  input  logic        game_over,
`ifdef PONG_PAUSE_EN
  input  logic        pause_btn,
  output logic        paused,
`endif
  output logic        pad_start,
  input  logic        pad_done,
  output logic        ball_start,
  input  logic        ball_done,
  output logic        score_start,
  input  logic        score_done,
  output logic        frame_tick,
  output logic        busy,
  output logic        overrun,
  output logic [1:0]  game_state,
  output logic [15:0] frame_cnt
);

  logic        frame_edge;
  logic        deadline;
  logic        paused_int;
  logic        fresh_q;
  logic [2:0]  mask_now;
  logic [2:0]  mask_q;
  logic [SCW-1:0] cnt_q, cnt_d;
  seq_state_t  seq_q, seq_d;
  game_state_t gs_q, gs_d;

  assign frame_edge = (sx == '0) && (sy == 10'(VA_END + 1));
  assign deadline   = (sx == '0) && (sy == 10'(SCREEN));

  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      frame_tick <= 1'b0;
      frame_cnt  <= '0;
      overrun    <= 1'b0;
    end else begin
      frame_tick <= frame_edge;
      if (frame_edge) frame_cnt <= frame_cnt + 16'd1;
      if (deadline && seq_q != S_IDLE) overrun <= 1'b1;
    end
  end

  always_comb begin
    mask_now = 3'b000;
    unique case (gs_q)
      PLAY:    mask_now = 3'b111;
      SERVE:   mask_now = 3'b001;
      default: mask_now = 3'b000;
    endcase
    if (paused_int) mask_now = 3'b000;
  end

  // fresh_q marks the strobe cycle; a done seen then is too early
  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      seq_q   <= S_IDLE;
      fresh_q <= 1'b0;
      mask_q  <= 3'b000;
    end else begin
      seq_q   <= seq_d;
      fresh_q <= (seq_d != S_IDLE) && (seq_d != seq_q);
      if (frame_tick && seq_q == S_IDLE) mask_q <= mask_now;
    end
  end

  always_comb begin
    seq_d = seq_q;
    unique case (seq_q)
      S_IDLE:
        if (frame_tick) seq_d = pick_phase(mask_now);
      S_PAD:
        if (pad_done && !fresh_q)
          seq_d = pick_phase(mask_q & 3'b110);
      S_BALL:
        if (ball_done && !fresh_q)
          seq_d = pick_phase(mask_q & 3'b100);
      S_SCORE:
        if (score_done && !fresh_q) seq_d = S_IDLE;
      default: seq_d = S_IDLE;
    endcase
    if (deadline && seq_q != S_IDLE) seq_d = S_IDLE;
  end

  always_comb begin
    pad_start   = fresh_q && (seq_q == S_PAD);
    ball_start  = fresh_q && (seq_q == S_BALL);
    score_start = fresh_q && (seq_q == S_SCORE);
    busy        = (seq_q != S_IDLE);
  end

  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      gs_q  <= ATTRACT;
      cnt_q <= '0;
    end else begin
      gs_q  <= gs_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    gs_d  = gs_q;
    cnt_d = cnt_q;
    unique case (gs_q)
      ATTRACT, OVER:
        if (start_btn) begin
          gs_d  = SERVE;
          cnt_d = SCW'(SERVE_FRAMES);
        end
      SERVE:
        if (frame_tick && !paused_int) begin
          if (cnt_q == SCW'(1)) gs_d = PLAY;
          cnt_d = cnt_q - SCW'(1);
        end
      PLAY:
        if (game_over) begin
          gs_d = OVER;
        end else if (point_scored) begin
          gs_d  = SERVE;
          cnt_d = SCW'(SERVE_FRAMES);
        end
      default: gs_d = gs_q;
    endcase
  end

  assign game_state = gs_q;

`ifdef PONG_PAUSE_EN
  always_ff @(posedge clk_pix) begin
    if (rst_pix)
      paused <= 1'b0;
    else if (gs_d == ATTRACT || gs_d == OVER)
      paused <= 1'b0;
    else if (pause_btn && (gs_q == PLAY || gs_q == SERVE))
      paused <= ~paused;
  end

  assign paused_int = paused;
`else
  assign paused_int = 1'b0;
`endif

endmodule

// File: doc/pong_frame_seq.md
Name: pong_frame_seq

Overview:
- Per-frame scheduler for the Pong game logic, clocked in the pixel domain alongside the 640x480 display timing generator.
- Detects the start of vertical blanking from sx/sy, then sequences three update units (paddle, ball, score) one after another using start/done handshakes.
- Holds the top-level game-mode FSM (attract/serve/play/over) that selects which phases run each frame.
- Flags any frame whose updates fail to finish before blanking ends.

Parameters:
- VA_END, 479, last active line; the frame boundary is line VA_END+1, column 0.
- SCREEN, 524, last line of the frame; the deadline is line SCREEN, column 0.
- SERVE_FRAMES, 60, number of frame_ticks spent in SERVE before PLAY.
- SCW, 8, width of the serve countdown; SERVE_FRAMES must be less than 2**SCW.

Ports:
- clk_pix  in  1  pixel clock
- rst_pix  in  1  synchronous active-high reset, pixel clock domain
- sx  in  10  horizontal position from display timing
- sy  in  10  vertical position from display timing
- start_btn  in  1  debounced start request, level
- point_scored  in  1  one-cycle pulse from the score unit
- game_over  in  1  one-cycle pulse from the score unit
- pad_start  out  1  one-cycle start strobe to the paddle unit
- pad_done  in  1  paddle update complete, pulse
- ball_start  out  1  one-cycle start strobe to the ball unit
- ball_done  in  1  ball update complete, pulse
- score_start  out  1  one-cycle start strobe to the score unit
- score_done  in  1  score update complete, pulse
- frame_tick  out  1  one-cycle pulse per frame
- busy  out  1  high while the sequencer is not in S_IDLE
- overrun  out  1  sticky deadline-miss flag
- game_state  out  2  0 ATTRACT, 1 SERVE, 2 PLAY, 3 OVER
- frame_cnt  out  16  count of frame_ticks, wraps

Behaviour:
- Reset: all outputs 0. game_state=ATTRACT, sequencer in S_IDLE, serve counter=0, frame_cnt=0, overrun=0. Reset while a phase is in flight aborts it with no further strobes.
- frame_tick timing: registered. If cycle N shows sx==0 and sy==VA_END+1, frame_tick is high in cycle N+1. frame_cnt increments in the same cycle.
- Phase mask: sampled from game_state on frame_tick.
  - PLAY: pad, ball, score.
  - SERVE: pad only.
  - ATTRACT and OVER: none.
- Sequencer states: S_IDLE, S_PAD, S_BALL, S_SCORE.
  - On frame_tick with a non-empty mask, move to the first enabled phase.
  - The phase's start strobe is high for exactly the first cycle in that state, i.e. cycle N+2 for the first phase.
  - A phase waits for its own done. That done is accepted no earlier than the cycle after the strobe.
  - On done, move to the next enabled phase (its strobe fires the following cycle), or to S_IDLE if none remain.
  - A done on a phase not being waited on is ignored.
- Deadline:
  - If sx==0 and sy==SCREEN while not in S_IDLE: go to S_IDLE next cycle and set overrun. overrun stays set until reset.
  - A done arriving in the same cycle as the deadline: the deadline wins and no further strobe is issued.
- frame_tick while busy: cannot occur given the deadline rule. If it does, it is ignored for sequencing but still counted.
- Game FSM:
  - ATTRACT: start_btn goes to SERVE and loads the counter with SERVE_FRAMES.
  - SERVE: each frame_tick decrements the counter. On a frame_tick with the counter at 1, go to PLAY.
  - PLAY: point_scored goes to SERVE and reloads the counter. game_over goes to OVER. If both arrive together, game_over wins.
  - OVER: start_btn goes to SERVE and reloads the counter.
  - point_scored and game_over are ignored outside PLAY. start_btn is ignored in SERVE and PLAY.
  - State changes take effect the next cycle. The current frame's phase mask is not altered mid-frame.

Optional Feature:
- Macro: PONG_PAUSE_EN.
- When defined: adds input port pause_btn (1 bit, single-cycle pulse). In PLAY or SERVE, each pulse toggles an internal paused flag.
  - While paused, the phase mask is forced empty and the serve counter holds.
  - frame_tick and frame_cnt continue normally.
  - paused clears on reset and on any transition into ATTRACT or OVER.
  - Output paused (1 bit) is exported.
- When undefined: no pause_btn or paused ports, and behaviour is exactly as above.

Decomposition:
- pong_pkg holds:
  - game_state_t enum: ATTRACT, SERVE, PLAY, OVER.
  - seq_state_t enum.
  - Shared timing constants: H_ACTIVE_END, V_ACTIVE_END, LINE_LAST, SCREEN_LAST, so they match the display timing generator.
- No sub-module is needed. The frame/deadline detector and both FSMs live in one module.

Test Plan:
- Reset, then sx=0/sy=480 in PLAY: frame_tick at N+1, pad_start at N+2. pad_done at N+5 gives ball_start at N+6; ball_done then score_done returns the sequencer to idle; frame_cnt=1.
- SERVE with SERVE_FRAMES=3: only pad_start per frame. After the 3rd frame_tick game_state=2. The 4th frame issues all three strobes.
- Deadline: withhold ball_done until sy=524/sx=0. busy drops next cycle, overrun=1, score_start never fires. overrun holds across later frames.
- point_scored and game_over in the same cycle while in PLAY: game_state=3. Stray pad_done while idle produces no strobe.
- Reset mid-S_BALL: all outputs 0 next cycle. ball_done afterwards is ignored; game_state=0.
- With PONG_PAUSE_EN, pause_btn in PLAY: frame_tick continues, no *_start strobes. A second pause_btn resumes strobes on the next frame.
